ro_freq_counter: RTL and testbench

RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

---
 rtl/ro_freq_counter.sv | 121 ++++++++++++
 tb/tb_ro_freq_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter.
// ro_in is synchronised into the clk domain. Its rising edges are counted over a
// programmable window of clk cycles. The result is then held with a valid/ready handshake.
// Optional feature: define RO_CNT_SATURATE_EN to make count saturate at all-ones
// instead of wrapping. overflow is set in either mode.
module ro_freq_counter #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned WIN_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIN_WIDTH-1:0] window,
  input  logic                 ro_in,
  output logic [WIDTH-1:0]     count,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StHold
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_pulse;
  logic [WIN_WIDTH-1:0]   win_cnt_q;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_inc;
  logic                   overflow_q;
  logic                   busy_q;
  logic                   valid_q;

  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign valid    = valid_q;

  // The synchroniser and the edge-history flop run in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Next count value on an edge. All-ones either wraps to zero or sticks at all-ones.
  always_comb begin
    count_inc = count_q + WIDTH'(1);
`ifdef RO_CNT_SATURATE_EN
    if (&count_q) count_inc = count_q;
`else
    count_inc = count_q + WIDTH'(1);
`endif
  end

  // Measurement FSM. busy and valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      win_cnt_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            if (window != '0) begin
              win_cnt_q <= window;
              state_q   <= StMeasure;
              busy_q    <= 1'b1;
            end else begin
              state_q <= StHold;
              valid_q <= 1'b1;
            end
          end
        end
        StMeasure: begin
          win_cnt_q <= win_cnt_q - WIN_WIDTH'(1);
          if (edge_pulse) begin
            count_q <= count_inc;
            if (&count_q) overflow_q <= 1'b1;
          end
          // The last window cycle still counts its edge before handing off.
          if (win_cnt_q == WIN_WIDTH'(1)) begin
            state_q <= StHold;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter.
// It drives a default-width instance and a WIDTH=4 instance with the same inputs.
module tb_ro_freq_counter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] window;
  logic        ro_in;
  logic        ready;
  logic [11:0] count;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic [3:0]  count_s;
  logic        valid_s;
  logic        busy_s;
  logic        overflow_s;

  int n_cmp;
  int n_fail;
  bit tog_en;

  ro_freq_counter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .window   (window),
    .ro_in    (ro_in),
    .count    (count),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .overflow (overflow)
  );

  ro_freq_counter #(.WIDTH(4)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .window   (window),
    .ro_in    (ro_in),
    .count    (count_s),
    .valid    (valid_s),
    .ready    (ready),
    .busy     (busy_s),
    .overflow (overflow_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: wait for the edge, settle, then optionally toggle the oscillator input.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tog_en) ro_in = ~ro_in;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    n_cmp++; if (count !== 12'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_basic_window;
    tog_en = 1'b1;
    ready  = 1'b0;
    tick(10);
    start  = 1'b1;
    window = 16'd100;
    tick(1);
    start  = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b want 1", busy); end
    tick(99);
    n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_last_measure busy=%b valid=%b want 1/0", busy, valid);
    end
    tick(1);
    n_cmp++; if (valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_valid busy=%b valid=%b want 0/1", busy, valid);
    end
    n_cmp++; if (count !== 12'd50) begin n_fail++; $display("FAIL basic_count got %0d want 50", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got %b want 0", overflow); end
`ifdef RO_CNT_SATURATE_EN
    n_cmp++; if (count_s !== 4'd15) begin n_fail++; $display("FAIL basic_small_count got %0d want 15", count_s); end
`else
    n_cmp++; if (count_s !== 4'd2) begin n_fail++; $display("FAIL basic_small_count got %0d want 2", count_s); end
`endif
    n_cmp++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL basic_small_ovf got %b want 1", overflow_s); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept valid got %b want 0", valid); end
    tick(6);
    n_cmp++; if (count !== 12'd50) begin n_fail++; $display("FAIL idle_retain count got %0d want 50", count); end
  endtask

  task automatic test_zero_window;
    bit saw_busy;
    saw_busy = 1'b0;
    start  = 1'b1;
    window = 16'd0;
    tick(1);
    start = 1'b0;
    if (busy) saw_busy = 1'b1;
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b want 1", valid); end
    n_cmp++; if (count !== 12'd0) begin n_fail++; $display("FAIL zero_count got %0d want 0", count); end
    ready = 1'b1;
    tick(1);
    if (busy) saw_busy = 1'b1;
    ready = 1'b0;
    n_cmp++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", saw_busy); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL zero_accept valid got %b want 0", valid); end
  endtask

  task automatic test_overflow;
    tog_en = 1'b1;
    start  = 1'b1;
    window = 16'd40;
    tick(1);
    start = 1'b0;
    tick(40);
    n_cmp++; if (valid_s !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b want 1", valid_s); end
`ifdef RO_CNT_SATURATE_EN
    n_cmp++; if (count_s !== 4'd15) begin n_fail++; $display("FAIL ovf_count got %0d want 15", count_s); end
`else
    n_cmp++; if (count_s !== 4'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count_s); end
`endif
    n_cmp++; if (overflow_s !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_s); end
    n_cmp++; if (count !== 12'd20 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_wide count=%0d ovf=%b want 20/0", count, overflow);
    end
  endtask

  // Runs from HOLD, which the preceding test leaves the DUTs in.
  task automatic test_hold;
    int bad;
    bad = 0;
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start  = i[0];
      window = 16'd3;
      tick(1);
      if (count !== 12'd20 || valid !== 1'b1 || busy !== 1'b0) bad++;
    end
    start = 1'b0;
    n_cmp++; if (bad !== 0) begin
      n_fail++; $display("FAIL hold_stable bad_cycles got %0d want 0", bad);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release valid=%b busy=%b want 0/0", valid, busy);
    end
    start  = 1'b1;
    window = 16'd5;
    tick(1);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_restart busy got %b want 1", busy); end
    tick(5);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    tog_en = 1'b1;
    start  = 1'b1;
    window = 16'd100;
    tick(1);
    start = 1'b0;
    tick(50);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_cmp++; if (count !== 12'd0 || busy !== 1'b0 || valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset count=%0d busy=%b valid=%b ovf=%b want 0/0/0/0",
               count, busy, valid, overflow);
    end
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(99);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_full busy got %b want 1", busy); end
    tick(1);
    n_cmp++; if (valid !== 1'b1 || count !== 12'd50) begin
      n_fail++; $display("FAIL midreset_rerun valid=%b count=%0d want 1/50", valid, count);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic test_constant_input;
    tog_en = 1'b0;
    ro_in  = 1'b1;
    tick(5);
    start  = 1'b1;
    window = 16'd30;
    tick(1);
    start = 1'b0;
    tick(30);
    n_cmp++; if (valid !== 1'b1 || count !== 12'd0) begin
      n_fail++; $display("FAIL const_high valid=%b count=%0d want 1/0", valid, count);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    ro_in = 1'b0;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(15);
    ro_in = 1'b1;
    tick(15);
    n_cmp++; if (valid !== 1'b1 || count !== 12'd1) begin
      n_fail++; $display("FAIL single_step valid=%b count=%0d want 1/1", valid, count);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tog_en = 1'b0;
    reset  = 1'b1;
    start  = 1'b0;
    window = 16'd0;
    ro_in  = 1'b0;
    ready  = 1'b0;
    test_reset();
    test_basic_window();
    test_zero_window();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_constant_input();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
